// File: rtl/text_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : text_buffer                                                   |
// | Purpose  : Character/attribute store with display fetch, host write and  |
// |            readback, whole-screen fill engine and optional vertical      |
// |            scroll offset (enabled by defining TEXTBUF_SCROLL_EN).         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module text_buffer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 25,
  parameter int ATTR_W    = 32,
  parameter int XW        = 7,
  parameter int YW        = 5,
  parameter     INIT_FILE = "data/initial_screen.txt"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_char,
  input  logic [XW-1:0]     xtext,
  input  logic [YW-1:0]     ytext,
  output logic [ATTR_W-1:0] char_out,
  input  logic              wr_req,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [ATTR_W-1:0] wr_value,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic [ATTR_W-1:0] rd_value,
  output logic              rd_valid,
  input  logic              fill_start,
  input  logic [ATTR_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              scroll_set,
  input  logic [YW-1:0]     scroll_row
);

  localparam int c_DEPTH = COLS * ROWS;
  localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_FILL = 1'b1;

  logic [ATTR_W-1:0] r_mem [0:c_DEPTH-1];

  // Row start addresses as constants; rows beyond ROWS pad the table to 2**YW.
  logic [c_AW-1:0] w_row_base [0:(1<<YW)-1];

  for (genvar r = 0; r < (1 << YW); r++) begin : g_row_base
    if (r < ROWS) begin : g_valid
      assign w_row_base[r] = c_AW'(r * COLS);
    end else begin : g_pad
      assign w_row_base[r] = '0;
    end
  end

  // Shared read port: display fetch owns it whenever load_char is high.
  logic [XW-1:0]     w_rd_x;
  logic [YW-1:0]     w_rd_y;
  logic [YW-1:0]     w_rd_phys;
  logic [YW-1:0]     w_wr_phys;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [c_AW-1:0]   w_rd_addr;
  logic [c_AW-1:0]   w_wr_addr;
  logic [ATTR_W-1:0] w_rd_word;
  logic              w_host_rd;

  assign w_rd_x = load_char ? xtext : rd_x;
  assign w_rd_y = load_char ? ytext : rd_y;

`ifdef TEXTBUF_SCROLL_EN
  logic [YW-1:0] r_scroll;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scroll <= '0;
    end else if (scroll_set && (32'(scroll_row) < ROWS)) begin
      r_scroll <= scroll_row;
    end
  end

  // Both operands are below ROWS, so one conditional subtract gives the modulo.
  function automatic logic [YW-1:0] f_phys_row(input logic [YW-1:0] y,
                                               input logic [YW-1:0] s);
    logic [YW:0] sum;
    sum = {1'b0, y} + {1'b0, s};
    if (32'(sum) >= ROWS) sum = sum - (YW+1)'(ROWS);
    return sum[YW-1:0];
  endfunction

  assign w_rd_phys = f_phys_row(w_rd_y, r_scroll);
  assign w_wr_phys = f_phys_row(wr_y, r_scroll);
`else
  logic w_unused_scroll;
  assign w_unused_scroll = &{1'b0, scroll_set, scroll_row};
  assign w_rd_phys       = w_rd_y;
  assign w_wr_phys       = wr_y;
`endif

  assign w_rd_ok   = (32'(w_rd_x) < COLS) && (32'(w_rd_y) < ROWS);
  assign w_wr_ok   = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
  assign w_rd_addr = w_row_base[w_rd_phys] + c_AW'(w_rd_x);
  assign w_wr_addr = w_row_base[w_wr_phys] + c_AW'(wr_x);
  assign w_rd_word = r_mem[w_rd_addr];

  // rd_valid high means the host still sees the previous answer; skip re-service.
  assign w_host_rd = rd_req && !load_char && !rd_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_out <= '0;
      rd_value <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= w_host_rd;
      if (load_char) begin
        char_out <= w_rd_ok ? w_rd_word : '0;
      end
      if (w_host_rd) begin
        rd_value <= w_rd_ok ? w_rd_word : '0;
      end
    end
  end

  // Fill engine
  logic [0:0]        r_state;
  logic [c_AW-1:0]   r_fill_addr;
  logic [ATTR_W-1:0] r_fill_value;

  assign fill_busy = (r_state == c_FILL);
  assign wr_ready  = !fill_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_fill_addr  <= '0;
      r_fill_value <= '0;
      fill_done    <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (fill_start) begin
            r_state      <= c_FILL;
            r_fill_addr  <= '0;
            r_fill_value <= fill_value;
          end
        end
        c_FILL: begin
          if (r_fill_addr == c_AW'(c_DEPTH - 1)) begin
            r_state   <= c_IDLE;
            fill_done <= 1'b1;
          end else begin
            r_fill_addr <= r_fill_addr + c_AW'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Single write port: fill owns it while busy, host otherwise.
  logic              w_mem_we;
  logic [c_AW-1:0]   w_mem_waddr;
  logic [ATTR_W-1:0] w_mem_wdata;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = w_wr_addr;
    w_mem_wdata = wr_value;
    if (r_state == c_FILL) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_fill_addr;
      w_mem_wdata = r_fill_value;
    end else if (wr_req && w_wr_ok) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer.sv
`default_nettype none
// Self-checking bench for text_buffer: directed steps plus randomized host
// traffic compared against an array model of the logical screen.
module tb_text_buffer;
  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int ATTR_W = 32;
  localparam int XW     = 7;
  localparam int YW     = 5;
`ifdef TEXTBUF_SCROLL_EN
  localparam bit SCROLL_EN = 1'b1;
`else
  localparam bit SCROLL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_char = 1'b0;
  logic [XW-1:0]     xtext = '0;
  logic [YW-1:0]     ytext = '0;
  logic [ATTR_W-1:0] char_out;
  logic              wr_req = 1'b0;
  logic [XW-1:0]     wr_x = '0;
  logic [YW-1:0]     wr_y = '0;
  logic [ATTR_W-1:0] wr_value = '0;
  logic              wr_ready;
  logic              rd_req = 1'b0;
  logic [XW-1:0]     rd_x = '0;
  logic [YW-1:0]     rd_y = '0;
  logic [ATTR_W-1:0] rd_value;
  logic              rd_valid;
  logic              fill_start = 1'b0;
  logic [ATTR_W-1:0] fill_value = '0;
  logic              fill_busy;
  logic              fill_done;
  logic              scroll_set = 1'b0;
  logic [YW-1:0]     scroll_row = '0;

  text_buffer #(
    .COLS(COLS), .ROWS(ROWS), .ATTR_W(ATTR_W), .XW(XW), .YW(YW), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .load_char(load_char), .xtext(xtext), .ytext(ytext), .char_out(char_out),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_value(wr_value), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_value(rd_value), .rd_valid(rd_valid),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy),
    .fill_done(fill_done), .scroll_set(scroll_set), .scroll_row(scroll_row)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model of the physical screen plus the current scroll offset
  logic [ATTR_W-1:0] m_mem [0:COLS*ROWS-1];
  int                m_scroll = 0;

  function automatic int maddr(input int x, input int y);
    return ((y + m_scroll) % ROWS) * COLS + x;
  endfunction

  function automatic logic [ATTR_W-1:0] mexp(input int x, input int y);
    if (x >= COLS || y >= ROWS) return '0;
    return m_mem[maddr(x, y)];
  endfunction

  task automatic check(input string tag, input logic [ATTR_W-1:0] obs,
                       input logic [ATTR_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic host_write(input int x, input int y, input logic [ATTR_W-1:0] v);
    wr_req = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_value = v;
    check("wr_ready_idle", wr_ready, 1);
    @(negedge clk);
    wr_req = 1'b0;
    if (x < COLS && y < ROWS) m_mem[maddr(x, y)] = v;
  endtask

  task automatic host_read(input int x, input int y, input string tag);
    logic [ATTR_W-1:0] e;
    int n;
    e = mexp(x, y);
    rd_req = 1'b1; rd_x = XW'(x); rd_y = YW'(y);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_valid && n < 20);
    rd_req = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check(tag, rd_value, e);
  endtask

  task automatic fetch(input int x, input int y, input string tag);
    logic [ATTR_W-1:0] e;
    e = mexp(x, y);
    load_char = 1'b1; xtext = XW'(x); ytext = YW'(y);
    @(negedge clk);
    load_char = 1'b0;
    check(tag, char_out, e);
  endtask

  task automatic set_scroll(input int v);
    scroll_set = 1'b1; scroll_row = YW'(v);
    @(negedge clk);
    scroll_set = 1'b0;
    if (SCROLL_EN && v < ROWS) m_scroll = v;
  endtask

  initial begin
    int busy_cnt, done_cnt, wr_bad, n, errs, x, y;
    logic [ATTR_W-1:0] v, held;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_char_out", char_out, 0);
    check("rst_rd_value", rd_value, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_fill_done", fill_done, 0);
    reset = 1'b1;
    @(negedge clk);

    // Fill 0x20 with a simultaneous write, a host write held throughout and a
    // second fill_start mid-way that must be ignored.
    fill_start = 1'b1; fill_value = 32'h0000_0020;
    wr_req = 1'b1; wr_x = 7'd5; wr_y = 5'd5; wr_value = 32'hDEAD_BEEF;
    @(negedge clk);
    fill_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; wr_bad = 0; n = 0;
    while (fill_busy && n < 2100) begin
      busy_cnt++;
      if (wr_ready !== 1'b0) wr_bad++;
      if (fill_done) done_cnt++;
      fill_start = (n == 500);
      fill_value = (n == 500) ? 32'h0000_0077 : 32'h0000_0020;
      @(negedge clk);
      n++;
    end
    wr_req = 1'b0; fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (fill_done) done_cnt++;
      @(negedge clk);
    end
    check("fill_busy_cycles", busy_cnt, 2000);
    check("fill_done_pulses", done_cnt, 1);
    check("fill_wr_ready_low", wr_bad, 0);
    check("fill_idle_after", fill_busy, 0);
    for (int i = 0; i < COLS * ROWS; i++) m_mem[i] = 32'h0000_0020;

    fetch(0, 0, "fill_fetch_first");
    fetch(79, 24, "fill_fetch_last");
    host_read(5, 5, "fill_read_simul_wr");
    for (int i = 0; i < 4; i++) begin
      fetch($urandom_range(0, COLS - 1), $urandom_range(0, ROWS - 1), "fill_fetch_rand");
      host_read($urandom_range(0, COLS - 1), $urandom_range(0, ROWS - 1), "fill_read_rand");
    end

    // Write then read back
    host_write(3, 2, 32'h0000_1241);
    fetch(3, 2, "wr_fetch_3_2");
    held = char_out;
    @(negedge clk);
    check("char_out_held", char_out, held);
    host_read(3, 2, "wr_read_3_2");
    host_write(80, 3, 32'h1111_2222);
    host_write(4, 25, 32'h3333_4444);
    fetch(80, 3, "oor_fetch_x");
    host_read(4, 25, "oor_read_y");
    fetch(0, 3, "oor_write_dropped");

    // Arbitration: read held behind four cycles of display fetch
    rd_req = 1'b1; rd_x = 7'd3; rd_y = 5'd2;
    load_char = 1'b1; xtext = 7'd0; ytext = 5'd0;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_valid !== 1'b0) errs++;
    end
    load_char = 1'b0;
    check("arb_no_valid_during_fetch", errs, 0);
    @(negedge clk);
    check("arb_valid_after_drop", rd_valid, 1);
    check("arb_rd_value", rd_value, mexp(3, 2));
    check("arb_char_out", char_out, mexp(0, 0));
    rd_req = 1'b0;
    @(negedge clk);
    check("arb_valid_single", rd_valid, 0);

    // Same-cycle read and write of one address returns old data
    v = mexp(10, 10);
    rd_req = 1'b1; rd_x = 7'd10; rd_y = 5'd10;
    wr_req = 1'b1; wr_x = 7'd10; wr_y = 5'd10; wr_value = 32'hCAFE_0001;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    m_mem[maddr(10, 10)] = 32'hCAFE_0001;
    check("rw_same_valid", rd_valid, 1);
    check("rw_same_old", rd_value, v);
    fetch(10, 10, "rw_same_new");

    // Scroll
    host_write(0, 5, 32'h0000_00AA);
    set_scroll(3);
    fetch(0, 2, "scroll_fetch_0_2");
    fetch(0, 5, "scroll_fetch_0_5");
    set_scroll(30);
    fetch(0, 2, "scroll_ignore_30");

    // Randomized traffic under the current scroll
    for (int i = 0; i < 24; i++) begin
      x = $urandom_range(0, COLS + 3);
      y = $urandom_range(0, ROWS + 3);
      case ($urandom_range(0, 3))
        0: host_write(x, y, $urandom);
        1: host_read(x, y, "rand_read");
        2: fetch(x, y, "rand_fetch");
        default: set_scroll($urandom_range(0, ROWS + 4));
      endcase
    end

    // Asynchronous reset in the middle of a fill
    fetch(0, 5, "pre_reset_fetch");
    fill_start = 1'b1; fill_value = 32'h0000_0033;
    @(negedge clk);
    fill_start = 1'b0;
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_fill_busy", fill_busy, 0);
    check("areset_char_out", char_out, 0);
    check("areset_rd_valid", rd_valid, 0);
    check("areset_wr_ready", wr_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (fill_done || fill_busy) done_cnt++;
    end
    check("areset_no_fill_done", done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
